dvi_timing_gen: RTL
===================

# dvi_timing_gen

Video timing generator and pixel sink sitting directly downstream of `PatternGenerator`. It produces SVGA 800x600 raster timing (HSync/VSync/DE), and asserts `VideoReady` only during the active region to pull 24-bit pixels. It registers each accepted pixel toward the DVI transmitter and substitutes black when the source underflows.

## Interface
- `H_ACTIVE`, 800: visible pixels per line
- `H_FP`, 40: horizontal front porch, in pixels
- `H_SYNC`, 128: horizontal sync width, in pixels
- `H_BP`, 88: horizontal back porch, in pixels
- `V_ACTIVE`, 600: visible lines per frame
- `V_FP`, 1: vertical front porch, in lines
- `V_SYNC`, 4: vertical sync width, in lines
- `V_BP`, 23: vertical back porch, in lines
- `SYNC_POL`, 1: asserted level of `DviHSync`/`DviVSync`
- `Clock  in  1`: pixel clock, rising edge
- `Reset  in  1`: asynchronous, active-low reset
- `VideoValid  in  1`: source has a pixel; tie to 1 for `PatternGenerator`
- `Video  in  24`: pixel {R,G,B}, 8 bits each
- `VideoReady  out  1`: pixel requested this cycle
- `DviData  out  24`: registered pixel to the transmitter
- `DviDE  out  1`: data enable
- `DviHSync  out  1`: horizontal sync
- `DviVSync  out  1`: vertical sync
- `FrameStart  out  1`: one-cycle pulse with the first pixel of each frame
- `Underflow  out  1`: one-cycle pulse per starved pixel

## Operation
- Derived totals: H_TOTAL = sum of the four H parameters (1056); V_TOTAL = sum of the four V parameters (628).
- Counters:
  - `hcnt` runs 0..H_TOTAL-1 and wraps to 0.
  - `vcnt` increments when `hcnt` wraps, and wraps to 0 after V_TOTAL-1.
  - Widths are clog2 of the totals.
- Run flag: reset to 0, set on the first clock edge after `Reset` rises. Counters hold at 0 while run=0.
- `active` = run && hcnt < H_ACTIVE && vcnt < V_ACTIVE.
- `VideoReady` = `active`, decoded combinationally from the registered counters and run flag. A transfer occurs on every edge where `VideoReady` && `VideoValid`.
- Pixel path, on an active cycle:
  - `VideoValid`=1: `DviData` <= `Video`.
  - `VideoValid`=0: `DviData` <= 24'h000000 and `Underflow` pulses.
  - The raster never stalls; the source must keep pace.
- Blanking cycles: `DviData` <= 0 and `DviDE` <= 0.
- HSync is asserted for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC, on every line including vertical blanking.
- VSync is asserted for V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC, for whole lines (aligned to hcnt=0).
- `FrameStart` = registered (active && hcnt==0 && vcnt==0).

## Timing
- Reset values (asynchronous, while `Reset`=0):
  - counters = 0, run = 0
  - `VideoReady` = 0, `DviData` = 0, `DviDE` = 0
  - `DviHSync` = `DviVSync` = ~SYNC_POL
  - `FrameStart` = 0, `Underflow` = 0
- Latency: all Dvi* outputs, `FrameStart` and `Underflow` lag the counter decode by exactly 1 cycle. The sync-to-DE relationship is preserved.
- First pixel:
  - Reset release, then edge 1: run=1.
  - During the next cycle, `VideoReady`=1.
  - Edge 2: `DviDE`=1, `DviData` = pixel (0,0), `FrameStart`=1.
- Per line: 800 DE cycles, then 40 blank, 128 HSync, 88 blank.
- Frame period: 663168 cycles.
- Reset mid-frame: outputs return to reset values immediately. After release, the sequence restarts from pixel (0,0); there is no partial-frame resume.
- `VideoValid` outside the active region is ignored and nothing is consumed.

## Configuration
- `DVI_UNDERFLOW_CNT_EN` defined:
  - Adds output `UnderflowCount  out  16`: saturating count of starved pixels.
  - Reset to 0 by `Reset`.
  - Also cleared synchronously on the cycle `FrameStart` asserts, so it reports the previous frame's total. On that cycle the count restarts from that cycle's underflow, 0 or 1.
- Undefined: port and counter absent. `Underflow` pulse behaviour is unchanged.

## Test plan
- Hold `Reset`=0 for 3 cycles, then release -> all outputs at reset values during reset. `VideoReady`=1 on cycle 2 after release. `DviDE`=1 with `FrameStart`=1 one cycle later.
- `Video`=24'h8e44ad constant, `VideoValid`=1, run one line -> exactly 800 `DviDE` cycles carrying 0x8e44ad, then 40 blank. `DviHSync`=1 for 128 cycles, then 88 blank, with `VideoReady`=0 throughout blanking.
- Run a full frame -> `FrameStart` pulses repeat every 663168 cycles. `DviVSync` is high for 4x1056 cycles starting at line 601, and `DviDE` is never high during vertical blanking.
- Drop `VideoValid` for 3 active cycles mid-line -> `DviData`=0 and `DviDE`=1 on those 3 output cycles. 3 `Underflow` pulses. With the macro, `UnderflowCount`=3 until the next `FrameStart`, then 0.
- Assert `Reset` at line 300, pixel 400 -> outputs go to reset values without a clock edge. After release, the first output is pixel (0,0) with `FrameStart`.
- Feed the `PatternGenerator` stream with `SYNC_POL`=0 -> syncs idle high and pulse low. DE and pixel data are identical to the `SYNC_POL`=1 run.

Source files
------------

// File: rtl/dvi_timing_gen.sv
// SVGA raster timing generator and pixel sink: free-running H/V counters, registered DVI outputs.
// Define DVI_UNDERFLOW_CNT_EN to add the per-frame saturating UnderflowCount output.
module dvi_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        VideoValid,
  input  logic [23:0] Video,
  output logic        VideoReady,
  output logic [23:0] DviData,
  output logic        DviDE,
  output logic        DviHSync,
  output logic        DviVSync,
  output logic        FrameStart,
  output logic        Underflow
`ifdef DVI_UNDERFLOW_CNT_EN
  ,
  output logic [15:0] UnderflowCount
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int          HW      = $clog2(H_TOTAL);
  localparam int          VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] HLast = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] VLast = VW'(V_TOTAL - 1);

  localparam int unsigned HSyncStart = H_ACTIVE + H_FP;
  localparam int unsigned HSyncEnd   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VSyncStart = V_ACTIVE + V_FP;
  localparam int unsigned VSyncEnd   = V_ACTIVE + V_FP + V_SYNC;

  localparam logic SyncIdle = ~SYNC_POL;

  logic          runQ;
  logic [HW-1:0] hCntQ, hCntD;
  logic [VW-1:0] vCntQ, vCntD;

  logic active;
  logic hSyncDec;
  logic vSyncDec;
  logic firstPix;
  logic starved;

  // Counters hold at the origin until run is set, so the first visible pixel is always (0,0).
  always_comb begin
    hCntD = hCntQ;
    vCntD = vCntQ;
    if (runQ) begin
      if (hCntQ == HLast) begin
        hCntD = '0;
        vCntD = (vCntQ == VLast) ? '0 : vCntQ + 1'b1;
      end else begin
        hCntD = hCntQ + 1'b1;
      end
    end
  end

  always_comb begin
    active   = runQ && (32'(hCntQ) < H_ACTIVE) && (32'(vCntQ) < V_ACTIVE);
    hSyncDec = runQ && (32'(hCntQ) >= HSyncStart) && (32'(hCntQ) < HSyncEnd);
    vSyncDec = runQ && (32'(vCntQ) >= VSyncStart) && (32'(vCntQ) < VSyncEnd);
    firstPix = active && (hCntQ == '0) && (vCntQ == '0);
    starved  = active && !VideoValid;
  end

  assign VideoReady = active;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      runQ  <= 1'b0;
      hCntQ <= '0;
      vCntQ <= '0;
    end else begin
      runQ  <= 1'b1;
      hCntQ <= hCntD;
      vCntQ <= vCntD;
    end
  end

  // All outputs share one register stage so sync, DE and data stay aligned.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      DviData    <= '0;
      DviDE      <= 1'b0;
      DviHSync   <= SyncIdle;
      DviVSync   <= SyncIdle;
      FrameStart <= 1'b0;
      Underflow  <= 1'b0;
    end else begin
      DviData    <= (active && VideoValid) ? Video : 24'h000000;
      DviDE      <= active;
      DviHSync   <= hSyncDec ? SYNC_POL : SyncIdle;
      DviVSync   <= vSyncDec ? SYNC_POL : SyncIdle;
      FrameStart <= firstPix;
      Underflow  <= starved;
    end
  end

`ifdef DVI_UNDERFLOW_CNT_EN
  logic [15:0] uCntQ;

  // Restarts on the frame's first pixel, counting that pixel if it was itself starved.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      uCntQ <= '0;
    end else if (firstPix) begin
      uCntQ <= {15'b0, starved};
    end else if (starved && (uCntQ != 16'hFFFF)) begin
      uCntQ <= uCntQ + 16'd1;
    end
  end

  assign UnderflowCount = uCntQ;
`endif

endmodule
